// File: rtl/k2_pkg.sv
// Shared types, instruction field positions and class decoder for the K2 sequencer.
// K2_HALT_DETECT_EN adds the HALT state used by self-jump halt detection.
package k2_pkg;

    localparam int J_BIT  = 7;
    localparam int C_BIT  = 6;
    localparam int D_HI   = 5;
    localparam int D_LO   = 4;
    localparam int S_BIT  = 3;
    localparam int IMM_HI = 2;
    localparam int IMM_LO = 0;

`ifdef K2_HALT_DETECT_EN
    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM_WAIT,
        S_HALT
    } state_t;
`else
    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM_WAIT
    } state_t;
`endif

    typedef enum logic [2:0] {
        CLS_JMP,
        CLS_JZ,
        CLS_JC,
        CLS_LD,
        CLS_ST,
        CLS_ALU,
        CLS_NOP
    } instr_class_t;

    // Checks are ordered so the first matching J/C/S/D pattern wins.
    function automatic instr_class_t decode_class(input logic [7:0] instr);
        logic       j;
        logic       c;
        logic       s;
        logic [1:0] d;
        instr_class_t cls;
        j   = instr[J_BIT];
        c   = instr[C_BIT];
        s   = instr[S_BIT];
        d   = instr[D_HI:D_LO];
        cls = CLS_NOP;
        if (j && !c)
            cls = CLS_JMP;
        else if (j && c && !s)
            cls = CLS_JZ;
        else if (!j && c && !s)
            cls = CLS_JC;
        else if (j && c && s)
            cls = CLS_LD;
        else if (!j && c && s && (d == 2'b11))
            cls = CLS_ST;
        else if (!j && !c)
            cls = CLS_ALU;
        return cls;
    endfunction

endpackage

// File: rtl/k2_decode.sv
// Combinational instruction decoder: word -> instruction class and jump target.
module k2_decode
    import k2_pkg::*;
#(
    parameter int PC_W = 4,
    parameter int IW   = 8
) (
    input  logic [IW-1:0]   i_instr,
    output instr_class_t    o_class,
    output logic [PC_W-1:0] o_target
);

    logic [2:0] w_imm;

    assign w_imm    = i_instr[IMM_HI:IMM_LO];
    assign o_class  = decode_class(i_instr);
    assign o_target = PC_W'(w_imm);

endmodule

// File: rtl/k2_seq_ctrl.sv
// K2 multi-cycle sequencer: fetch/decode/exec FSM, PC, flags and store handshake.
// K2_HALT_DETECT_EN enables the halted port and halting on a self-targeted JMP.
module k2_seq_ctrl
    import k2_pkg::*;
#(
    parameter int PC_W = 4,
    parameter int IW   = 8
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    input  logic            imem_valid,
    input  logic [IW-1:0]   imem_data,
    output logic [PC_W-1:0] pc,
    input  logic            alu_zf,
    input  logic            alu_cf,
    output logic            zf,
    output logic            cf,
    output logic            reg_we,
    output logic            data_sel,
    output logic            dmem_en,
    input  logic            dmem_ready,
    output logic            jump_taken
`ifdef K2_HALT_DETECT_EN
    ,
    output logic            halted
`endif
);

    state_t          r_state;
    state_t          w_stateNext;
    logic [IW-1:0]   r_instr;
    logic [PC_W-1:0] r_pc;
    logic            r_zf;
    logic            r_cf;
    logic            r_run;

    instr_class_t    w_class;
    logic [PC_W-1:0] w_target;
    logic            w_taken;
    logic            w_irLoad;
    logic            w_pcLoad;
    logic            w_pcInc;
    logic            w_flagWe;

    k2_decode #(
        .PC_W (PC_W),
        .IW   (IW)
    ) u_decode (
        .i_instr  (r_instr),
        .o_class  (w_class),
        .o_target (w_target)
    );

    // Conditional jumps look only at the registered flags.
    assign w_taken = (w_class == CLS_JMP)
                   || ((w_class == CLS_JZ) && r_zf)
                   || ((w_class == CLS_JC) && r_cf);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_FETCH;
        else
            r_state <= w_stateNext;
    end

    always_comb begin
        w_stateNext = r_state;
        imem_req    = 1'b0;
        reg_we      = 1'b0;
        data_sel    = 1'b0;
        dmem_en     = 1'b0;
        jump_taken  = 1'b0;
        w_irLoad    = 1'b0;
        w_pcLoad    = 1'b0;
        w_pcInc     = 1'b0;
        w_flagWe    = 1'b0;
        case (r_state)
            S_FETCH: begin
                imem_req = r_run;
                if (r_run && imem_valid) begin
                    w_irLoad    = 1'b1;
                    w_stateNext = S_DECODE;
                end
            end
            S_DECODE: w_stateNext = S_EXEC;
            S_EXEC: begin
                w_stateNext = S_FETCH;
                case (w_class)
                    CLS_JMP, CLS_JZ, CLS_JC: begin
                        if (w_taken) begin
                            w_pcLoad   = 1'b1;
                            jump_taken = 1'b1;
`ifdef K2_HALT_DETECT_EN
                            if ((w_class == CLS_JMP) && (w_target == r_pc))
                                w_stateNext = S_HALT;
`endif
                        end else begin
                            w_pcInc = 1'b1;
                        end
                    end
                    CLS_LD: begin
                        reg_we   = 1'b1;
                        data_sel = 1'b1;
                        w_pcInc  = 1'b1;
                    end
                    CLS_ALU: begin
                        reg_we   = 1'b1;
                        w_flagWe = 1'b1;
                        w_pcInc  = 1'b1;
                    end
                    CLS_ST:  w_stateNext = S_MEM_WAIT;
                    default: w_pcInc = 1'b1;
                endcase
            end
            S_MEM_WAIT: begin
                dmem_en = 1'b1;
                if (dmem_ready) begin
                    w_pcInc     = 1'b1;
                    w_stateNext = S_FETCH;
                end
            end
`ifdef K2_HALT_DETECT_EN
            S_HALT: w_stateNext = S_HALT;
`endif
            default: w_stateNext = S_FETCH;
        endcase
    end

    // r_run keeps imem_req low until the first clock after reset releases.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_run   <= 1'b0;
            r_instr <= '0;
            r_pc    <= '0;
            r_zf    <= 1'b0;
            r_cf    <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (w_irLoad)
                r_instr <= imem_data;
            if (w_pcLoad)
                r_pc <= w_target;
            else if (w_pcInc)
                r_pc <= r_pc + PC_W'(1);
            if (w_flagWe) begin
                r_zf <= alu_zf;
                r_cf <= alu_cf;
            end
        end
    end

    assign pc = r_pc;
    assign zf = r_zf;
    assign cf = r_cf;
`ifdef K2_HALT_DETECT_EN
    assign halted = (r_state == S_HALT);
`endif

endmodule

// File: tb/tb_k2_seq_ctrl.sv
// Self-checking bench for k2_seq_ctrl: directed scenarios plus random programs
// checked against an instruction-level model (K2_HALT_DETECT_EN aware).
module tb_k2_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       imem_valid = 1'b0;
    logic [7:0] imem_data = 8'h00;
    logic       alu_zf = 1'b0;
    logic       alu_cf = 1'b0;
    logic       dmem_ready = 1'b0;
    logic       imem_req;
    logic [3:0] pc;
    logic       zf;
    logic       cf;
    logic       reg_we;
    logic       data_sel;
    logic       dmem_en;
    logic       jump_taken;
`ifdef K2_HALT_DETECT_EN
    logic       halted;
`endif

    int         nAsserts = 0;
    int         nFail = 0;
    logic [3:0] mPc;
    logic       mZf;
    logic       mCf;
    logic       mHalt;
    logic [7:0] rIns;

    k2_seq_ctrl #(
        .PC_W (4),
        .IW   (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_valid (imem_valid),
        .imem_data  (imem_data),
        .pc         (pc),
        .alu_zf     (alu_zf),
        .alu_cf     (alu_cf),
        .zf         (zf),
        .cf         (cf),
        .reg_we     (reg_we),
        .data_sel   (data_sel),
        .dmem_en    (dmem_en),
        .dmem_ready (dmem_ready),
        .jump_taken (jump_taken)
`ifdef K2_HALT_DETECT_EN
        ,
        .halted     (halted)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one instruction through the DUT; the model works per instruction.
    task automatic applyStimulus(input logic [7:0] instr, input logic aZf, input logic aCf,
                                 input int fetchDelay, input int readyDelay);
        logic       j;
        logic       c;
        logic       s;
        logic       isJmp;
        logic       isJz;
        logic       isJc;
        logic       isLd;
        logic       isSt;
        logic       isAlu;
        logic       taken;
        logic [3:0] imm;
        int         waitCnt;
        j     = instr[7];
        c     = instr[6];
        s     = instr[3];
        imm   = {1'b0, instr[2:0]};
        isJmp = j && !c;
        isJz  = j && c && !s;
        isJc  = !j && c && !s;
        isLd  = j && c && s;
        isSt  = !j && c && s && (instr[5:4] == 2'b11);
        isAlu = !j && !c;
        taken = isJmp || (isJz && mZf) || (isJc && mCf);

        waitCnt = 0;
        while (imem_req !== 1'b1 && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("fetchReq", imem_req, 1);
        checkOutput("fetchPc", pc, mPc);
        for (int k = 0; k < fetchDelay; k++) begin
            imem_valid = 1'b0;
            imem_data  = 8'($urandom);
            dmem_ready = 1'($urandom);
            @(negedge clk);
            checkOutput("reqHold", imem_req, 1);
        end
        imem_valid = 1'b1;
        imem_data  = instr;
        @(negedge clk);
        imem_valid = 1'($urandom);
        imem_data  = 8'($urandom);
        dmem_ready = 1'($urandom);
        alu_zf     = aZf;
        alu_cf     = aCf;
        checkOutput("decReq", imem_req, 0);
        checkOutput("decRegWe", reg_we, 0);
        checkOutput("decJump", jump_taken, 0);
        @(negedge clk);
        imem_valid = 1'b0;
        dmem_ready = 1'($urandom);
        checkOutput("exRegWe", reg_we, isAlu || isLd);
        checkOutput("exDataSel", data_sel, isLd);
        checkOutput("exJump", jump_taken, taken);
        checkOutput("exDmemEn", dmem_en, 0);
        checkOutput("exReq", imem_req, 0);
        @(negedge clk);
        if (isSt) begin
            for (int k = 0; k <= readyDelay; k++) begin
                checkOutput("stDmemEn", dmem_en, 1);
                checkOutput("stPcHold", pc, mPc);
                dmem_ready = (k == readyDelay);
                @(negedge clk);
            end
            dmem_ready = 1'b0;
        end
        if (isAlu) begin
            mZf = aZf;
            mCf = aCf;
        end
`ifdef K2_HALT_DETECT_EN
        if (isJmp && (imm == mPc))
            mHalt = 1'b1;
`endif
        mPc = taken ? imm : 4'(mPc + 4'd1);
        checkOutput("postPc", pc, mPc);
        checkOutput("postZf", zf, mZf);
        checkOutput("postCf", cf, mCf);
        checkOutput("postJump", jump_taken, 0);
        checkOutput("postRegWe", reg_we, 0);
        checkOutput("postDmemEn", dmem_en, 0);
        checkOutput("postReq", imem_req, !mHalt);
    endtask

    initial begin
        mPc   = 4'd0;
        mZf   = 1'b0;
        mCf   = 1'b0;
        mHalt = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rstPc", pc, 0);
        checkOutput("rstZf", zf, 0);
        checkOutput("rstCf", cf, 0);
        checkOutput("rstReq", imem_req, 0);
        checkOutput("rstDmemEn", dmem_en, 0);
        checkOutput("rstRegWe", reg_we, 0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reqAfterRst", imem_req, 1);

        applyStimulus(8'h00, 1'b0, 1'b1, 0, 0);
        applyStimulus(8'h45, 1'b1, 1'b1, 0, 0);
        checkOutput("jcPc", pc, 5);
        checkOutput("jcCf", cf, 1);

        applyStimulus(8'h82, 1'b0, 1'b0, 1, 0);
        applyStimulus(8'h00, 1'b0, 1'b0, 0, 0);
        applyStimulus(8'hC2, 1'b1, 1'b1, 0, 0);
        checkOutput("jzPc", pc, 4);

        applyStimulus(8'h78, 1'b0, 1'b0, 0, 3);
        checkOutput("stPc", pc, 5);

        applyStimulus(8'h87, 1'b0, 1'b0, 0, 0);
        for (int k = 0; k < 8; k++)
            applyStimulus(8'h48, 1'b1, 1'b1, 0, 0);
        checkOutput("ldStartPc", pc, 15);
        applyStimulus(8'hC8, 1'b1, 1'b1, 0, 0);
        checkOutput("ldWrapPc", pc, 0);
        checkOutput("ldZf", zf, 0);

        applyStimulus(8'h00, 1'b1, 1'b1, 0, 0);
        imem_valid = 1'b1;
        imem_data  = 8'h78;
        @(negedge clk);
        imem_valid = 1'b0;
        @(negedge clk);
        dmem_ready = 1'b0;
        @(negedge clk);
        checkOutput("abortEnBefore", dmem_en, 1);
        @(negedge clk);
        checkOutput("abortEnStill", dmem_en, 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("abortDmemEn", dmem_en, 0);
        checkOutput("abortPc", pc, 0);
        checkOutput("abortZf", zf, 0);
        checkOutput("abortCf", cf, 0);
        checkOutput("abortReq", imem_req, 0);
        @(negedge clk);
        checkOutput("abortReqHeld", imem_req, 0);
        reset = 1'b0;
        mPc   = 4'd0;
        mZf   = 1'b0;
        mCf   = 1'b0;
        @(negedge clk);
        checkOutput("abortReqRise", imem_req, 1);

        applyStimulus(8'h82, 1'b0, 1'b0, 0, 0);
`ifdef K2_HALT_DETECT_EN
        applyStimulus(8'h82, 1'b0, 1'b0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checkOutput("haltFlag", halted, 1);
            checkOutput("haltReq", imem_req, 0);
            checkOutput("haltPc", pc, 2);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mPc   = 4'd0;
        mZf   = 1'b0;
        mCf   = 1'b0;
        mHalt = 1'b0;
        @(negedge clk);
        checkOutput("haltCleared", halted, 0);
`else
        for (int k = 0; k < 3; k++)
            applyStimulus(8'h82, 1'b0, 1'b0, 0, 0);
        checkOutput("selfJmpPc", pc, 2);
`endif

        for (int n = 0; n < 150; n++) begin
            rIns = 8'($urandom);
`ifdef K2_HALT_DETECT_EN
            if (rIns[7:6] == 2'b10 && {1'b0, rIns[2:0]} == mPc)
                rIns = 8'h48;
`endif
            applyStimulus(rIns, 1'($urandom), 1'($urandom),
                          int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule

// File: doc/k2_seq_ctrl.md
# k2_seq_ctrl

Multi-cycle instruction sequencer for the K2 core. Fetches one instruction per pass over a request/valid handshake and decodes its J/C/D/S fields. Owns the program counter and the registered ZF/CF flags, resolves conditional jumps, and sequences data-memory stores with a ready handshake. Sits between instruction memory, the ALU flag outputs, the register-file write port and data memory.

## Interface
- Parameters:
- `PC_W`, 4: program counter width; jump target is `imm` zero-extended to `PC_W`.
- `IW`, 8: instruction width; fields `[7]`J, `[6]`C, `[5:4]`D, `[3]`S, `[2:0]`imm; `IW` must be 8.
- Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `imem_req` out 1: fetch request.
- `imem_valid` in 1: instruction word valid.
- `imem_data` in `IW`: instruction word.
- `pc` out `PC_W`: current program counter.
- `alu_zf`, `alu_cf` in 1: combinational ALU flags for the current instruction.
- `zf`, `cf` out 1: registered flags.
- `reg_we` out 1: register-file write strobe.
- `data_sel` out 1: selects memory data onto the register write bus.
- `dmem_en` out 1: data-memory store enable.
- `dmem_ready` in 1: store accepted.
- `jump_taken` out 1: one-cycle pulse when the PC loads a target.

## Operation
- Decode classes, in priority order:
  - J=1,C=0: unconditional jump (JMP).
  - J=1,C=1,S=0: jump if `zf` (JZ).
  - J=0,C=1,S=0: jump if `cf` (JC).
  - J=1,C=1,S=1: load (LD). `data_sel`=1, `reg_we`=1, flags unchanged.
  - J=0,C=1,S=1,D=11: store (ST).
  - J=0,C=1,S=1,D≠11: NOP.
  - J=0,C=0: ALU op. `reg_we`=1; `zf`/`cf` capture `alu_zf`/`alu_cf`.
- Conditional jumps test the registered flags, never the ALU inputs.
- States: FETCH, DECODE, EXEC, MEM_WAIT, HALT.
  - FETCH: `imem_req`=1. On `imem_valid`, latch `imem_data` into the instruction register and go to DECODE.
  - DECODE: one cycle. Go to EXEC.
  - EXEC, jump class: taken -> `pc`<=target and `jump_taken` pulse; not taken -> `pc`<=`pc`+1. Go to FETCH.
  - EXEC, ALU/LD/NOP: `pc`<=`pc`+1. Go to FETCH.
  - EXEC, ST: go to MEM_WAIT.
  - MEM_WAIT: `dmem_en` held at 1 until the cycle `dmem_ready`=1. In that cycle, `pc`<=`pc`+1 and go to FETCH.
- PC arithmetic is modulo 2^`PC_W`; `pc`+1 at all-ones wraps to 0.
- `reg_we`, `data_sel` and `jump_taken` are high for the EXEC cycle only.
- `dmem_ready` is ignored outside MEM_WAIT. `imem_valid` is ignored outside FETCH.
- Reset asserted mid-operation (including MEM_WAIT) aborts immediately:
  - state FETCH; `pc`=0, `zf`=0, `cf`=0;
  - all strobes and `imem_req` 0 while reset is high.
  - `imem_req` rises the first cycle after reset deasserts.

## Timing
- Minimum instruction latency: 3 cycles (FETCH with same-cycle `imem_valid`, DECODE, EXEC).
- A store adds at least 1 MEM_WAIT cycle, plus one cycle per cycle `dmem_ready` stays low.
- Flags written in EXEC are visible to the next instruction's EXEC; there is no forwarding hazard.
- All outputs are registered or decoded from the state register plus the instruction register; none depends combinationally on `imem_valid` or `dmem_ready`.

## Configuration
- `K2_HALT_DETECT_EN` defined:
  - A JMP whose target equals the current `pc` enters HALT. `pc` holds and `imem_req`=0.
  - HALT exits only on reset.
  - `halted` out 1 is present and is 1 in HALT.
- Undefined: no HALT state and no `halted` port. A self-JMP loops normally, with a `jump_taken` pulse every pass.

## Structure
- Package `k2_pkg` holds:
  - `state_t` enum;
  - `instr_class_t` enum (JMP, JZ, JC, LD, ST, ALU, NOP);
  - field-position localparams;
  - `decode_class()` function.
- Sub-module `k2_decode`: combinational, instruction word -> class and target.
- The FSM, PC and flag registers stay in `k2_seq_ctrl`.

## Test plan
- Reset mid-MEM_WAIT (`dmem_ready`=0): assert `reset` -> `dmem_en`=0 and `pc`=0 asynchronously; `imem_req`=1 one cycle after release.
- ALU op with `alu_cf`=1, `alu_zf`=0, then JC to imm=5 -> `cf`=1, `pc`=5, single `jump_taken` pulse.
- ALU op setting `zf`=0, then JZ imm=2 at `pc`=3 -> not taken, `pc`=4, no `jump_taken`.
- ST with `dmem_ready` low 3 cycles -> `dmem_en` high exactly 4 cycles, then `pc` increments once.
- LD at `pc`=15 (`PC_W`=4) -> `data_sel`=`reg_we`=1 for one cycle, `pc` wraps to 0, flags unchanged.
- JMP imm=2 at `pc`=2 -> with `K2_HALT_DETECT_EN`, `halted`=1 and `imem_req`=0 forever; without it, `imem_req` recurs every 3 cycles.
